// File: rtl/nib_to_word.sv
// Assembles LSB-first 4-bit packets from the SPI slave into word_width-bit words,
// with a one-cycle word strobe, per-transfer word count and sticky pad-bit error.
module nib_to_word #(
  parameter int unsigned word_width = 24,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_write_active,
  input  logic [3:0]            i_nib,
  input  logic                  i_nib_valid,
  output logic [word_width-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_busy,
  output logic [cnt_width-1:0]  o_word_cnt,
  output logic                  o_pad_err
);

  localparam int unsigned packages_per_word = ((word_width - 1) / 4) + 1;
  localparam int unsigned sh_width          = packages_per_word * 4;
  localparam int unsigned pad_bits          = sh_width - word_width;
  localparam int unsigned nib_cnt_width     = (packages_per_word > 1) ? $clog2(packages_per_word) : 1;

  localparam logic [nib_cnt_width-1:0] last_nib = nib_cnt_width'(packages_per_word - 1);
  // Bits of the final nibble that fall above word_width; zero mask when the word is nibble-aligned.
  localparam logic [3:0] pad_mask = 4'(4'hF << (4 - pad_bits));

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [sh_width-1:0]     shreg_q, shreg_d;
  logic [nib_cnt_width-1:0] nib_cnt_q, nib_cnt_d;
  logic [word_width-1:0]   word_q, word_d;
  logic                    word_valid_q, word_valid_d;
  logic                    busy_q, busy_d;
  logic [cnt_width-1:0]    word_cnt_q, word_cnt_d;
  logic                    pad_err_q, pad_err_d;

  logic                    accept;
  logic [sh_width-1:0]     sh_next;

  // State register and output flops; synchronous active-low reset.
  always_ff @(posedge i_clk_ILA) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      nib_cnt_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      word_cnt_q   <= '0;
      pad_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      nib_cnt_q    <= nib_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      word_cnt_q   <= word_cnt_d;
      pad_err_q    <= pad_err_d;
    end
  end

  // Next-state, assembly and bookkeeping.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    nib_cnt_d    = nib_cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    word_cnt_d   = word_cnt_q;
    pad_err_d    = pad_err_q;

    accept  = i_write_active & i_nib_valid;
    sh_next = shreg_q >> 4;
    sh_next[sh_width-1 -: 4] = i_nib;

    case (state_q)
      IDLE: begin
        if (i_write_active) state_d = COLLECT;
      end
      COLLECT: begin
        if (!i_write_active) begin
          state_d    = IDLE;
          shreg_d    = '0;
          nib_cnt_d  = '0;
          word_cnt_d = '0;
          pad_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (nib_cnt_q == last_nib) begin
        word_d       = sh_next[word_width-1:0];
        word_valid_d = 1'b1;
        shreg_d      = '0;
        nib_cnt_d    = '0;
        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + cnt_width'(1);
        if ((i_nib & pad_mask) != 4'd0) pad_err_d = 1'b1;
      end else begin
        shreg_d   = sh_next;
        nib_cnt_d = nib_cnt_q + nib_cnt_width'(1);
      end
    end

    busy_d = (nib_cnt_d != '0);
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;
  assign o_busy       = busy_q;
  assign o_word_cnt   = word_cnt_q;
  assign o_pad_err    = pad_err_q;

endmodule

// File: tb/tb_nib_to_word.sv
// Scoreboard bench for nib_to_word: a 24-bit/2-bit-counter instance and a 10-bit instance.
module tb_nib_to_word;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wa  [2];
  logic       nv  [2];
  logic [3:0] nib [2];

  logic [23:0] w0; logic v0, b0, p0; logic [1:0] c0;
  logic [9:0]  w1; logic v1, b1, p1; logic [7:0] c1;

  int total = 0;
  int bad   = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] cnt;
    logic        pad;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  nib_to_word #(.word_width(24), .cnt_width(2)) u_dut0 (
    .i_clk_ILA(clk), .i_reset(rst_n), .i_write_active(wa[0]), .i_nib(nib[0]),
    .i_nib_valid(nv[0]), .o_word(w0), .o_word_valid(v0), .o_busy(b0),
    .o_word_cnt(c0), .o_pad_err(p0)
  );

  nib_to_word #(.word_width(10), .cnt_width(8)) u_dut1 (
    .i_clk_ILA(clk), .i_reset(rst_n), .i_write_active(wa[1]), .i_nib(nib[1]),
    .i_nib_valid(nv[1]), .o_word(w1), .o_word_valid(v1), .o_busy(b1),
    .o_word_cnt(c1), .o_pad_err(p1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic a, input logic v, input logic [3:0] n);
    wa[i] = a; nv[i] = v; nib[i] = n;
  endtask

  task automatic push0(input logic [31:0] w, input logic [31:0] c, input logic p);
    exp_t e;
    e.word = w; e.cnt = c; e.pad = p;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] w, input logic [31:0] c, input logic p);
    exp_t e;
    e.word = w; e.cnt = c; e.pad = p;
    q1.push_back(e);
  endtask

  // Send one 24-bit word to instance 0, LSB nibble first, one nibble per cycle.
  task automatic send24(input logic [23:0] w);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, 1'b1, w[4*k +: 4]);
      tick();
    end
  endtask

  // Monitors: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      pulses0++;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected valid: got word 0x%0h with empty queue", w0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 word", 32'(w0), e.word);
        chk("dut0 cnt", 32'(c0), e.cnt);
        chk("dut0 pad_err", 32'(p0), 32'(e.pad));
      end
    end
  end

  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      pulses1++;
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected valid: got word 0x%0h with empty queue", w1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 word", 32'(w1), e.word);
        chk("dut1 cnt", 32'(c1), e.cnt);
        chk("dut1 pad_err", 32'(p1), 32'(e.pad));
      end
    end
  end

  initial begin
    logic [23:0] sw;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0);
    drive(1, 1'b0, 1'b0, 4'h0);
    tick(); tick();

    // reset state
    chk("rst w0", 32'(w0), 32'h0);   chk("rst v0", 32'(v0), 32'h0);
    chk("rst b0", 32'(b0), 32'h0);   chk("rst c0", 32'(c0), 32'h0);
    chk("rst p0", 32'(p0), 32'h0);   chk("rst w1", 32'(w1), 32'h0);
    chk("rst b1", 32'(b1), 32'h0);   chk("rst c1", 32'(c1), 32'h0);
    rst_n = 1'b1;
    tick();

    // nibble strobe while idle is ignored
    drive(0, 1'b0, 1'b1, 4'h9);
    tick();
    chk("idle ignore busy", 32'(b0), 32'h0);
    chk("idle ignore cnt", 32'(c0), 32'h0);

    // single word 1..6
    push0(32'h654321, 32'd1, 1'b0);
    drive(0, 1'b1, 1'b1, 4'h1);
    tick();
    chk("busy after nib1", 32'(b0), 32'h1);
    for (int n = 2; n <= 6; n++) begin
      drive(0, 1'b1, 1'b1, 4'(n));
      tick();
    end
    chk("busy after nib6", 32'(b0), 32'h0);
    chk("cnt after word1", 32'(c0), 32'd1);
    drive(0, 1'b1, 1'b0, 4'h0);
    tick();
    chk("valid one cycle", 32'(v0), 32'h0);
    chk("word held", 32'(w0), 32'h654321);

    // abort clears count, keeps word
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    chk("abort cnt", 32'(c0), 32'h0);
    chk("abort word held", 32'(w0), 32'h654321);

    // back-to-back words 0..B
    push0(32'h543210, 32'd1, 1'b0);
    push0(32'hBA9876, 32'd2, 1'b0);
    for (int n = 0; n < 12; n++) begin
      drive(0, 1'b1, 1'b1, 4'(n));
      tick();
    end
    chk("b2b cnt", 32'(c0), 32'd2);

    // mid-word abort, with a stray strobe on the abort cycle
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    for (int n = 7; n <= 9; n++) begin
      drive(0, 1'b1, 1'b1, 4'(n));
      tick();
    end
    chk("partial busy", 32'(b0), 32'h1);
    drive(0, 1'b0, 1'b1, 4'hF);
    tick();
    chk("midabort valid", 32'(v0), 32'h0);
    chk("midabort busy", 32'(b0), 32'h0);
    chk("midabort cnt", 32'(c0), 32'h0);
    chk("midabort word", 32'(w0), 32'hBA9876);
    push0(32'h654321, 32'd1, 1'b0);
    send24(24'h654321);
    chk("after abort cnt", 32'(c0), 32'd1);

    // reset mid-word
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(0, 1'b1, 1'b1, 4'hF); tick();
    drive(0, 1'b1, 1'b1, 4'hE); tick();
    drive(0, 1'b1, 1'b1, 4'hD); tick();
    drive(0, 1'b1, 1'b1, 4'hC); tick();
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 4'hB);
    tick();
    chk("midrst word", 32'(w0), 32'h0);
    chk("midrst busy", 32'(b0), 32'h0);
    chk("midrst cnt", 32'(c0), 32'h0);
    chk("midrst valid", 32'(v0), 32'h0);
    rst_n = 1'b1;
    push0(32'h123456, 32'd1, 1'b0);
    send24(24'h123456);
    chk("post rst cnt", 32'(c0), 32'd1);

    // saturating counter, 2-bit
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();
    begin
      int start;
      start = pulses0;
      for (int k = 0; k < 5; k++) begin
        sw = 24'h0;
        for (int i = 0; i < 6; i++) sw[4*i +: 4] = 4'((k * 3 + i) & 15);
        push0(32'(sw), (k < 2) ? 32'(k + 1) : 32'd3, 1'b0);
        send24(sw);
      end
      drive(0, 1'b1, 1'b0, 4'h0);
      tick();
      chk("sat pulses", 32'(pulses0 - start), 32'd5);
      chk("sat cnt", 32'(c0), 32'd3);
    end
    drive(0, 1'b0, 1'b0, 4'h0);
    tick();

    // 10-bit words and pad error
    push1(32'h3BA, 32'd1, 1'b0);
    drive(1, 1'b1, 1'b1, 4'hA); tick();
    drive(1, 1'b1, 1'b1, 4'hB); tick();
    drive(1, 1'b1, 1'b1, 4'h3); tick();
    chk("pad clean", 32'(p1), 32'h0);
    push1(32'h3BA, 32'd2, 1'b1);
    drive(1, 1'b1, 1'b1, 4'hA); tick();
    drive(1, 1'b1, 1'b1, 4'hB); tick();
    drive(1, 1'b1, 1'b1, 4'h7); tick();
    drive(1, 1'b1, 1'b0, 4'h0);
    tick(); tick();
    chk("pad sticky", 32'(p1), 32'h1);
    chk("pad word held", 32'(w1), 32'h3BA);
    drive(1, 1'b0, 1'b0, 4'h0);
    tick();
    chk("pad cleared", 32'(p1), 32'h0);
    chk("dut1 cnt cleared", 32'(c1), 32'h0);

    tick(); tick();
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    chk("pulses0", 32'(pulses0), 32'd10);
    chk("pulses1", 32'(pulses1), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nib_to_word.md
Name: nib_to_word

Overview:
- Receive-direction counterpart of the ILA sample-to-nibble serializer.
- Assembles a stream of 4-bit packets arriving from the SPI slave front-end into words of arbitrary width. Typical words are trigger/config words written by the host.
- Nibble order matches the transmit side: LSB nibble first.
- Sits between the SPI slave nibble interface and the ILA configuration registers. Issues a one-cycle word-valid strobe per completed word and counts words per host transfer.

Parameters:
- word_width, 24, width of the assembled word in bits (>=1).
- cnt_width, 8, width of the per-transfer word counter.
- Derived (localparam, not overridable):
  - packages_per_word = ((word_width-1)/4)+1
  - pad_bits = packages_per_word*4 - word_width
  - nib_cnt_width = max(1, $clog2(packages_per_word))

Ports:
- i_clk_ILA  in  1  ILA clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_write_active  in  1  host write transfer in progress; low = idle/abort.
- i_nib  in  4  incoming nibble; sampled only when i_nib_valid=1.
- i_nib_valid  in  1  one-cycle strobe per nibble; may be high on consecutive cycles.
- o_word  out  word_width  last completed word; held until next completion.
- o_word_valid  out  1  one-cycle pulse, word in o_word is new.
- o_busy  out  1  partial word collected (nibble count != 0).
- o_word_cnt  out  cnt_width  completed words in current transfer, saturating.
- o_pad_err  out  1  sticky per transfer: a final nibble carried nonzero bits above word_width.

Behaviour:
- Reset (i_reset=0 at clock edge), all registers cleared:
  - o_word=0, o_word_valid=0, o_busy=0, o_word_cnt=0, o_pad_err=0.
  - Shift register=0, nibble counter=0, state=IDLE.
  - Reset has priority over everything, including mid-word.
- State machine: IDLE, COLLECT.
  - IDLE: i_write_active=1 -> COLLECT, same edge. A nibble valid on that cycle is accepted.
  - COLLECT: i_write_active=0 -> IDLE. Abort clears:
    - shift register, nibble counter, o_busy, o_word_cnt, o_pad_err.
    - o_word keeps its last completed value.
    - o_word_valid is forced 0 on the abort cycle.
- Nibble accept condition: i_write_active=1 and i_nib_valid=1.
- On each accept:
  - Shift register (packages_per_word*4 bits) <= {i_nib, shreg[top:4]}. The first nibble ends at [3:0].
  - Nibble counter increments.
- Word completion: accept while nibble counter == packages_per_word-1. On that edge:
  - o_word <= {i_nib, shreg[top:4]}[word_width-1:0].
  - o_word_valid <= 1 for exactly one cycle.
  - Nibble counter <= 0, shift register <= 0.
  - o_word_cnt increments, saturating at all-ones.
  - If pad_bits>0 and i_nib[3:4-pad_bits] != 0, then o_pad_err <= 1. It stays set until abort or reset.
- Latency: o_word/o_word_valid are registered and appear the cycle after the final nibble's strobe edge.
- o_busy is registered: 1 when nibble counter != 0 after the edge.
- Throughput: one nibble per cycle sustained, no stall. A nibble accepted in the same cycle o_word_valid is high starts the next word normally.
- packages_per_word==1: every accept completes a word. The counter stays 0 and o_busy stays 0.
- i_nib_valid while i_write_active=0: ignored, no state change.
- Counters wrap:
  - Nibble counter wraps only via completion.
  - o_word_cnt never wraps; it saturates.

Test Plan:
- word_width=24: activate, nibbles 1,2,3,4,5,6 on consecutive cycles.
  -> o_word=0x654321 one cycle after nibble 6; o_word_valid high 1 cycle; o_word_cnt=1; o_busy 1 after nibble 1, 0 after nibble 6.
- word_width=24, back-to-back words: 12 consecutive nibbles 0..B.
  -> two valid pulses, o_word=0x543210 then 0xBA9876; o_word_cnt=2; no gap required.
- word_width=10: nibbles A,B,3 -> o_word=0x3BA, o_pad_err=0. Next word A,B,7 -> o_word=0x3BA, o_pad_err=1, held until i_write_active drops.
- word_width=24: 3 nibbles, then i_write_active=0 for 1 cycle, then 6 nibbles 1..6.
  -> no valid pulse on abort; counters cleared; o_word=0x654321 after the second sequence; o_word_cnt=1.
- i_reset=0 after 4 of 6 nibbles -> all outputs 0 next cycle; a following full 6-nibble word assembles correctly.
- cnt_width=2: 5 complete words -> o_word_cnt=1,2,3,3,3; o_word_valid pulses 5 times.
